// File: rtl/serial_subtractor_if.sv
// Operand/result bus for the bit-serial subtractor.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             i_start;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_diff;
   logic             o_borrow;

   // Requester side: issues operands, observes the result.
   modport master (
      output i_start, i_a, i_b,
      input  o_busy, o_done, o_diff, o_borrow
   );

   // Subtractor side.
   modport slave (
      input  i_start, i_a, i_b,
      output o_busy, o_done, o_diff, o_borrow
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first,
// with a registered borrow. Result and borrow are held until the next
// operation completes.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   serial_subtractor_if.slave  bus
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sr;
   logic             bw;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;

   logic             d;
   logic             bnext;
   logic [WIDTH-1:0] sr_next;

   // Full-subtractor cell on the current LSBs and the result shifted in at the top.
   always_comb begin
      d       = sa[0] ^ sb[0] ^ bw;
      bnext   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
      sr_next = {d, sr[WIDTH-1:1]};
   end

   // Control FSM and datapath registers; the final bit also commits the result.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         sa       <= '0;
         sb       <= '0;
         sr       <= '0;
         bw       <= 1'b0;
         cnt      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  sa    <= bus.i_a;
                  sb    <= bus.i_b;
                  bw    <= 1'b0;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sa <= sa >> 1;
               sb <= sb >> 1;
               sr <= sr_next;
               bw <= bnext;
               if (cnt == LAST) begin
                  // Counter parks at its terminal value; IDLE reloads it.
                  diff_q   <= sr_next;
                  borrow_q <= bnext;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status is decoded from the registered state; result comes from holding registers.
   assign bus.o_busy   = (state != IDLE);
   assign bus.o_done   = (state == DONE);
   assign bus.o_diff   = diff_q;
   assign bus.o_borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for the bit-serial subtractor (WIDTH = 8).
module tb_serial_subtractor;
   localparam int unsigned WIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic [WIDTH-1:0] hold_diff;
   logic             hold_borrow;

   serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full operation from IDLE; checks busy/done timing, result hold and result.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eb);
      bus.i_a     = a;
      bus.i_b     = b;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      bus.i_a     = ~a;
      bus.i_b     = a ^ b;
      for (int k = 1; k <= 9; k++) begin
         chk({tag, " busy"}, 32'(bus.o_busy), 32'd1);
         chk({tag, " done"}, 32'(bus.o_done), 32'(k == 9));
         if (k < 9) begin
            chk({tag, " diff hold"}, 32'(bus.o_diff), 32'(hold_diff));
            chk({tag, " borrow hold"}, 32'(bus.o_borrow), 32'(hold_borrow));
            tick();
         end
      end
      chk({tag, " diff"}, 32'(bus.o_diff), 32'(ed));
      chk({tag, " borrow"}, 32'(bus.o_borrow), 32'(eb));
      hold_diff   = ed;
      hold_borrow = eb;
      tick();
      chk({tag, " idle busy"}, 32'(bus.o_busy), 32'd0);
      chk({tag, " idle done"}, 32'(bus.o_done), 32'd0);
      chk({tag, " idle diff"}, 32'(bus.o_diff), 32'(ed));
   endtask

   initial begin
      int dones;
      int done_cyc;
      int last_done;
      logic [7:0] na, nb, ea, eb;

      // Reset, then idle with no start.
      rst         = 1'b1;
      bus.i_start = 1'b0;
      bus.i_a     = 8'h00;
      bus.i_b     = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      chk("reset busy", 32'(bus.o_busy), 32'd0);
      chk("reset done", 32'(bus.o_done), 32'd0);
      chk("reset diff", 32'(bus.o_diff), 32'd0);
      chk("reset borrow", 32'(bus.o_borrow), 32'd0);
      hold_diff   = 8'h00;
      hold_borrow = 1'b0;
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         bus.i_a = 8'(c * 7);
         bus.i_b = 8'(c * 3);
         tick();
         if (bus.o_done || bus.o_busy) dones++;
      end
      chk("idle activity", 32'(dones), 32'd0);
      chk("idle diff", 32'(bus.o_diff), 32'd0);
      chk("idle borrow", 32'(bus.o_borrow), 32'd0);

      // Directed operations.
      run_op("op 3c-15", 8'h3C, 8'h15, 8'h27, 1'b0);
      run_op("op 05-0a", 8'h05, 8'h0A, 8'hFB, 1'b1);
      run_op("op 00-ff", 8'h00, 8'hFF, 8'h01, 1'b1);
      run_op("op 80-80", 8'h80, 8'h80, 8'h00, 1'b0);

      // Second start while busy is ignored and not queued.
      bus.i_a     = 8'h10;
      bus.i_b     = 8'h01;
      bus.i_start = 1'b1;
      tick();
      dones    = 0;
      done_cyc = 0;
      for (int c = 1; c <= 14; c++) begin
         if (bus.o_done) begin
            dones++;
            done_cyc = c;
         end
         if (c == 4) begin
            bus.i_start = 1'b1;
            bus.i_a     = 8'hFF;
            bus.i_b     = 8'h00;
         end else begin
            bus.i_start = 1'b0;
         end
         tick();
      end
      chk("ignored start done count", 32'(dones), 32'd1);
      chk("ignored start done cycle", 32'(done_cyc), 32'd9);
      chk("ignored start diff", 32'(bus.o_diff), 32'h0F);
      chk("ignored start borrow", 32'(bus.o_borrow), 32'd0);
      chk("ignored start busy", 32'(bus.o_busy), 32'd0);
      hold_diff   = 8'h0F;
      hold_borrow = 1'b0;

      // Result holds during SHIFT; reset mid-operation abandons it.
      bus.i_a     = 8'h3C;
      bus.i_b     = 8'h15;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         chk("shift hold diff", 32'(bus.o_diff), 32'h0F);
         chk("shift busy", 32'(bus.o_busy), 32'd1);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid reset busy", 32'(bus.o_busy), 32'd0);
      chk("mid reset done", 32'(bus.o_done), 32'd0);
      chk("mid reset diff", 32'(bus.o_diff), 32'd0);
      chk("mid reset borrow", 32'(bus.o_borrow), 32'd0);
      hold_diff   = 8'h00;
      hold_borrow = 1'b0;
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (bus.o_done) dones++;
      end
      chk("mid reset no done", 32'(dones), 32'd0);
      run_op("op after reset", 8'h3C, 8'h15, 8'h27, 1'b0);

      // Reset and start together: reset wins.
      rst         = 1'b1;
      bus.i_start = 1'b1;
      bus.i_a     = 8'h01;
      bus.i_b     = 8'h02;
      tick();
      chk("rst+start busy", 32'(bus.o_busy), 32'd0);
      chk("rst+start diff", 32'(bus.o_diff), 32'd0);
      rst         = 1'b0;
      bus.i_start = 1'b0;
      tick();
      chk("rst+start after busy", 32'(bus.o_busy), 32'd0);
      chk("rst+start after done", 32'(bus.o_done), 32'd0);

      // Random operands with start held high continuously.
      na          = 8'($urandom);
      nb          = 8'($urandom);
      bus.i_a     = na;
      bus.i_b     = nb;
      bus.i_start = 1'b1;
      last_done   = 0;
      for (int i = 0; i < 1000; i++) begin
         ea = na;
         eb = nb;
         chk("rand idle busy", 32'(bus.o_busy), 32'd0);
         tick();
         na      = 8'($urandom);
         nb      = 8'($urandom);
         bus.i_a = na;
         bus.i_b = nb;
         repeat (7) tick();
         chk("rand early done", 32'(bus.o_done), 32'd0);
         tick();
         chk("rand done", 32'(bus.o_done), 32'd1);
         chk("rand diff", 32'(bus.o_diff), 32'(8'(ea - eb)));
         chk("rand borrow", 32'(bus.o_borrow), 32'(ea < eb));
         if (i > 0) chk("rand done spacing", 32'(cyc - last_done), 32'd10);
         last_done = cyc;
         tick();
      end
      bus.i_start = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor. Computes i_a - i_b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- It is the inverse-operation counterpart of the combinational full adder cell. It serves area-constrained datapaths that need a difference and a borrow flag.
- Operands are loaded with a start handshake. The result is presented with a one-cycle done pulse and held until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2)

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_start  input  1  request to begin a subtraction; honoured only in IDLE
- i_a  input  WIDTH  minuend; sampled on the edge that accepts i_start
- i_b  input  WIDTH  subtrahend; sampled on the edge that accepts i_start
- o_busy  output  1  high while in SHIFT or DONE
- o_done  output  1  one-cycle pulse; result valid
- o_diff  output  WIDTH  (i_a - i_b) mod 2^WIDTH
- o_borrow  output  1  final borrow out; 1 iff i_a < i_b (unsigned)

Behaviour:
- Reset (i_rst high at a rising edge):
  - state = IDLE
  - o_busy = 0, o_done = 0, o_diff = 0, o_borrow = 0
  - internal shift registers, borrow flop and bit counter = 0
  - Reset has priority over every other input, including mid-operation. The operation in flight is abandoned and no o_done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If i_start = 1: load sa <= i_a, sb <= i_b, bw <= 0, cnt <= 0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one bit per edge:
  - Cell: d = sa[0] ^ sb[0] ^ bw; bnext = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw).
  - Shift sa and sb right by 1. Shift d into the MSB of internal result register sr (right shift). bw <= bnext; cnt <= cnt + 1.
  - On the edge where cnt = WIDTH-1 (the WIDTH-th bit): additionally load o_diff <= final sr value (including this d) and o_borrow <= bnext; go to DONE.
  - cnt width = clog2(WIDTH). It never wraps; its terminal count is WIDTH-1.
- DONE:
  - o_done = 1 for exactly this one cycle; go to IDLE on the next edge.
- Outputs:
  - o_done and o_busy are decoded from registered state: o_done = (state == DONE); o_busy = (state != IDLE).
  - o_diff and o_borrow change only on the completion edge. They hold their previous result throughout SHIFT and after DONE, until the next completion or reset.
- Latency and throughput:
  - The edge accepting i_start is edge 0. o_done is high in the cycle after edge WIDTH, i.e. WIDTH+1 cycles after start is sampled.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Boundary conditions:
  - i_start while busy (SHIFT or DONE) is ignored with no side effects. It is not queued.
  - i_start held high continuously starts a new operation on the first edge back in IDLE.
  - i_a and i_b may change freely after the accepting edge.
  - Equal operands give o_diff = 0, o_borrow = 0.
  - i_a = 0, i_b = 2^WIDTH-1 gives o_diff = 1, o_borrow = 1.
  - i_rst and i_start both high: reset wins; remains IDLE.

Test Plan (WIDTH = 8):
- Reset then idle: after i_rst, all outputs 0 and o_busy = 0. i_start low for 20 cycles -> outputs unchanged.
- i_a = 0x3C, i_b = 0x15, pulse i_start -> o_done high exactly 9 cycles later; o_diff = 0x27, o_borrow = 0; o_busy high for cycles 1..9.
- i_a = 0x05, i_b = 0x0A -> o_diff = 0xFB, o_borrow = 1. Then i_a = 0x00, i_b = 0xFF -> o_diff = 0x01, o_borrow = 1. Then i_a = i_b = 0x80 -> o_diff = 0x00, o_borrow = 0.
- Pulse i_start with 0x10 - 0x01, then pulse i_start again at cycle 4 with 0xFF - 0x00. Second start is ignored: o_diff = 0x0F, and a single o_done is seen. o_diff stays 0x0F while a following operation is in SHIFT.
- Start 0x3C - 0x15 and assert i_rst at cycle 5 -> no o_done; o_diff = 0, o_busy = 0 next cycle. A fresh start afterwards computes correctly.
- Random: 1000 operations with random operands, i_start held high continuously -> each result equals (a - b) mod 256, borrow equals (a < b), and done pulses are spaced exactly 10 cycles apart.
